h_motor_step_monitor: RTL and testbench
=======================================

# h_motor_step_monitor

Receive-side monitor for the horizontal slip scan. It sits on the same clock as the horizontal motor controller and observes that controller's outputs: `h_pwm_pulse`, `h_pwm_dir`, `radar_ss` and `event_done`. From these it reconstructs motor position, slip progress and radar stop/start events, and flags motor steps that occur while the radar is stopped. At the end of each scan it emits a one-cycle summary for software readback.

## Interface
- `POS_W`, 32: width of the signed position accumulator.
- `SS_MIN_CYC`, 4: minimum `radar_ss` high width in clk cycles for a pulse to be accepted. Shorter pulses are glitches.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `data_update`  in  1: latches `pulses_per_slip` on the cycle it is high.
- `pulses_per_slip`  in  32: step pulses per slip (mini_step_nums × step_scale).
- `clear_pos`  in  1: synchronous clear of `position`, all counters and `err_step_in_dwell`.
- `h_pwm_pulse`  in  1: motor step pulse, possibly from a pin. Synchronised internally.
- `h_pwm_dir`  in  1: direction. 1 = +1 per step, 0 = −1 per step. Synchronised internally.
- `radar_ss`  in  1: radar stop/start strobe. Synchronised internally.
- `event_done`  in  1: scan-complete pulse, same clock domain. Not synchronised.
- `position`  out  POS_W: signed step position.
- `step_in_slip`  out  32: steps taken in the current slip.
- `slip_cnt`  out  32: slips completed in the current scan.
- `slip_done`  out  1: one-cycle pulse when a slip completes.
- `radar_stop_evt`, `radar_start_evt`  out  1: one-cycle pulses, one per accepted strobe.
- `radar_active`  out  1: radar running state as decoded from the strobes.
- `err_step_in_dwell`  out  1: sticky flag.
- `busy`  out  1: a scan is in progress.
- `scan_slips`, `scan_pairs`  out  32: end-of-scan summary values.
- `summary_valid`  out  1: one-cycle pulse qualifying `scan_slips` and `scan_pairs`.

## Operation
- **Reset values.** All outputs are 0 except `radar_active`, which resets to 1. The latched `pulses_per_slip` resets to 0.
- **Synchronisers.** `h_pwm_pulse`, `h_pwm_dir` and `radar_ss` each pass through a 2-FF synchroniser. A third register on the pulse and strobe paths provides edge detection.
- **Step.** A step is a rising edge of the synchronised pulse.
  - `position` += 1 if the synchronised dir is 1, else −= 1. Two's complement, wraps silently.
  - `busy` sets on any step.
- **Slip counting.**
  - On a step, if `step_in_slip + 1 >= ppslip` (the latched value): `step_in_slip` ← 0, `slip_cnt` += 1, `slip_done` pulses.
  - Otherwise `step_in_slip` += 1.
  - If `ppslip` is 0, slip counting is disabled: `step_in_slip` stays 0 and `slip_done` never pulses.
- **Strobe decoder.** States are `SS_LOW`, `SS_HIGH` and `SS_CHECK`.
  - `SS_LOW` → `SS_HIGH` on a synchronised rising edge. A width counter (16-bit, saturating) clears on entry.
  - In `SS_HIGH` the counter increments each cycle. On the falling edge, go to `SS_CHECK`.
  - In `SS_CHECK` (1 cycle): if width ≥ `SS_MIN_CYC`, the strobe is accepted, then return to `SS_LOW`.
  - An accepted strobe while `radar_active`=1 → `radar_stop_evt` pulses and `radar_active` ← 0.
  - An accepted strobe while `radar_active`=0 → `radar_start_evt` pulses, `radar_active` ← 1, and the pair counter += 1.
- **Dwell error.** A step while `radar_active`=0 sets `err_step_in_dwell`. The flag clears only on `clear_pos` or `rst`.
- **event_done.**
  - Next cycle: `scan_slips` ← `slip_cnt` and `scan_pairs` ← pair count, both including any coincident step or strobe. `summary_valid` pulses.
  - Same update: `slip_cnt`, `step_in_slip` and the pair counter clear, `busy` clears, and `radar_active` ← 1.
  - `position` is retained.

## Timing
- **Step latency.** The clk edge that first samples `h_pwm_pulse` high is edge N. `position`, `step_in_slip` and `slip_done` update at edge N+3.
- **Strobe latency.** Strobe events are registered 2 cycles after `SS_CHECK`. Measured from the input falling edge: 4 cycles.
- **Summary latency.** `summary_valid` asserts 1 cycle after `event_done`.
- **Pulse widths.** All event outputs are exactly 1 cycle wide.
- **Simultaneous events.**
  - `clear_pos` with a step: clear wins and the step is dropped.
  - `clear_pos` with `event_done`: the summary captures the pre-clear values, then everything clears.
  - `data_update` mid-slip: the new value applies from the next step. Because of the `>=` compare, a `step_in_slip` already beyond the new value wraps on that next step.
  - A strobe still high at `event_done`: the decoder completes normally into the new scan.
- **Reset mid-operation.** Everything returns to reset values immediately, including the synchronisers and the decoder state (`SS_LOW`).

## Test plan
- `ppslip`=4, dir=1, 10 steps → `position`=10, `slip_cnt`=2, `step_in_slip`=2, two `slip_done` pulses.
- dir=0, 3 steps from reset → `position`=−3. Then `clear_pos` coincident with a step → `position`=0.
- `radar_ss` high for 2 cycles → no event. High for 6 cycles → `radar_stop_evt` and `radar_active`=0. Another 6-cycle pulse → `radar_start_evt` and pair count 1.
- Step issued between a stop and a start → `err_step_in_dwell`=1, persists through `event_done`, clears on `clear_pos`.
- `ppslip`=4, 12 steps, 3 stop/start pairs, then `event_done` → one cycle later `summary_valid` with `scan_slips`=3 and `scan_pairs`=3. Counters read 0 and `position` stays 12.
- `rst` asserted mid-strobe and mid-slip → all outputs reset at once and `radar_active`=1. After release, a 6-cycle strobe is decoded as a stop.

Source files
------------

// File: rtl/h_motor_step_monitor.sv
// Horizontal slip-scan monitor: rebuilds motor position, slip progress and radar stop/start
// events from the motor controller outputs, and emits a per-scan summary on event_done.
module h_motor_step_monitor #(
   parameter int unsigned POS_W      = 32,
   parameter int unsigned SS_MIN_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_update,
   input  logic [31:0]      pulses_per_slip,
   input  logic             clear_pos,
   input  logic             h_pwm_pulse,
   input  logic             h_pwm_dir,
   input  logic             radar_ss,
   input  logic             event_done,
   output logic [POS_W-1:0] position,
   output logic [31:0]      step_in_slip,
   output logic [31:0]      slip_cnt,
   output logic             slip_done,
   output logic             radar_stop_evt,
   output logic             radar_start_evt,
   output logic             radar_active,
   output logic             err_step_in_dwell,
   output logic             busy,
   output logic [31:0]      scan_slips,
   output logic [31:0]      scan_pairs,
   output logic             summary_valid
);

   localparam logic [1:0]  SS_LOW    = 2'd0;
   localparam logic [1:0]  SS_HIGH   = 2'd1;
   localparam logic [1:0]  SS_CHECK  = 2'd2;
   localparam logic [15:0] SS_MIN_W  = 16'(SS_MIN_CYC);

   // [0],[1] synchroniser stages, [2] edge-detect history
   logic [2:0]       pulse_sync_q, ss_sync_q;
   logic [1:0]       dir_sync_q;
   logic             step_q, step_dir_q, accept_q;
   logic [1:0]       ss_state_q, ss_state_d;
   logic [15:0]      width_q, width_d;
   logic             accept;
   logic [31:0]      ppslip_q;

   logic [POS_W-1:0] pos_q, pos_d;
   logic [31:0]      sis_q, sis_d, slip_q, slip_d, pairs_q, pairs_d;
   logic [31:0]      scan_slips_q, scan_slips_d, scan_pairs_q, scan_pairs_d;
   logic             slip_done_q, slip_done_d, stop_q, stop_d, start_q, start_d;
   logic             active_q, active_d, err_q, err_d, busy_q, busy_d, valid_q, valid_d;
   logic             step_eff, ss_rise, ss_fall;

   assign ss_rise  = ss_sync_q[1] & ~ss_sync_q[2];
   assign ss_fall  = ~ss_sync_q[1] & ss_sync_q[2];
   assign step_eff = step_q & ~clear_pos;

   always_comb begin
      ss_state_d = ss_state_q;
      width_d    = width_q;
      accept     = 1'b0;
      case (ss_state_q)
         SS_LOW: begin
            if (ss_rise) begin
               ss_state_d = SS_HIGH;
               width_d    = '0;
            end
         end
         SS_HIGH: begin
            if (width_q != 16'hFFFF) width_d = width_q + 16'd1;
            if (ss_fall) ss_state_d = SS_CHECK;
         end
         SS_CHECK: begin
            accept     = (width_q >= SS_MIN_W);
            ss_state_d = SS_LOW;
         end
         default: ss_state_d = SS_LOW;
      endcase
   end

   always_comb begin
      pos_d        = pos_q;
      sis_d        = sis_q;
      slip_d       = slip_q;
      slip_done_d  = 1'b0;
      pairs_d      = pairs_q;
      stop_d       = accept_q & active_q;
      start_d      = accept_q & ~active_q;
      active_d     = accept_q ? ~active_q : active_q;
      err_d        = err_q | (step_eff & ~active_q);
      busy_d       = busy_q | step_eff;
      scan_slips_d = scan_slips_q;
      scan_pairs_d = scan_pairs_q;
      valid_d      = 1'b0;

      if (step_eff) pos_d = step_dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      if (step_eff && ppslip_q != 32'd0) begin
         if (sis_q + 32'd1 >= ppslip_q) begin
            sis_d       = '0;
            slip_d      = slip_q + 32'd1;
            slip_done_d = 1'b1;
         end else begin
            sis_d = sis_q + 32'd1;
         end
      end
      if (start_d) pairs_d = pairs_q + 32'd1;

      // Summary takes the values that include this cycle's step/strobe, before any clear
      if (event_done) begin
         scan_slips_d = slip_d;
         scan_pairs_d = pairs_d;
         valid_d      = 1'b1;
         sis_d        = '0;
         slip_d       = '0;
         pairs_d      = '0;
         busy_d       = 1'b0;
         active_d     = 1'b1;
      end
      if (clear_pos) begin
         pos_d   = '0;
         sis_d   = '0;
         slip_d  = '0;
         pairs_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_sync_q <= '0;
         ss_sync_q    <= '0;
         dir_sync_q   <= '0;
         step_q       <= 1'b0;
         step_dir_q   <= 1'b0;
         accept_q     <= 1'b0;
         ss_state_q   <= SS_LOW;
         width_q      <= '0;
         ppslip_q     <= '0;
         pos_q        <= '0;
         sis_q        <= '0;
         slip_q       <= '0;
         pairs_q      <= '0;
         slip_done_q  <= 1'b0;
         stop_q       <= 1'b0;
         start_q      <= 1'b0;
         active_q     <= 1'b1;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         scan_slips_q <= '0;
         scan_pairs_q <= '0;
         valid_q      <= 1'b0;
      end else begin
         pulse_sync_q <= {pulse_sync_q[1:0], h_pwm_pulse};
         ss_sync_q    <= {ss_sync_q[1:0], radar_ss};
         dir_sync_q   <= {dir_sync_q[0], h_pwm_dir};
         step_q       <= pulse_sync_q[1] & ~pulse_sync_q[2];
         step_dir_q   <= dir_sync_q[1];
         accept_q     <= accept;
         ss_state_q   <= ss_state_d;
         width_q      <= width_d;
         if (data_update) ppslip_q <= pulses_per_slip;
         pos_q        <= pos_d;
         sis_q        <= sis_d;
         slip_q       <= slip_d;
         pairs_q      <= pairs_d;
         slip_done_q  <= slip_done_d;
         stop_q       <= stop_d;
         start_q      <= start_d;
         active_q     <= active_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         scan_slips_q <= scan_slips_d;
         scan_pairs_q <= scan_pairs_d;
         valid_q      <= valid_d;
      end
   end

   assign position          = pos_q;
   assign step_in_slip      = sis_q;
   assign slip_cnt          = slip_q;
   assign slip_done         = slip_done_q;
   assign radar_stop_evt    = stop_q;
   assign radar_start_evt   = start_q;
   assign radar_active      = active_q;
   assign err_step_in_dwell = err_q;
   assign busy              = busy_q;
   assign scan_slips        = scan_slips_q;
   assign scan_pairs        = scan_pairs_q;
   assign summary_valid     = valid_q;

endmodule

// File: tb/tb_h_motor_step_monitor.sv
// Bench for h_motor_step_monitor: directed scenarios plus randomized step/strobe sequences
// compared against a transaction-level model of the scan.
module tb_h_motor_step_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_update = 1'b0;
   logic [31:0] pulses_per_slip = '0;
   logic        clear_pos = 1'b0;
   logic        h_pwm_pulse = 1'b0;
   logic        h_pwm_dir = 1'b0;
   logic        radar_ss = 1'b0;
   logic        event_done = 1'b0;
   logic [31:0] position, step_in_slip, slip_cnt, scan_slips, scan_pairs;
   logic        slip_done, radar_stop_evt, radar_start_evt, radar_active;
   logic        err_step_in_dwell, busy, summary_valid;

   h_motor_step_monitor #(.POS_W(32), .SS_MIN_CYC(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .data_update      (data_update),
      .pulses_per_slip  (pulses_per_slip),
      .clear_pos        (clear_pos),
      .h_pwm_pulse      (h_pwm_pulse),
      .h_pwm_dir        (h_pwm_dir),
      .radar_ss         (radar_ss),
      .event_done       (event_done),
      .position         (position),
      .step_in_slip     (step_in_slip),
      .slip_cnt         (slip_cnt),
      .slip_done        (slip_done),
      .radar_stop_evt   (radar_stop_evt),
      .radar_start_evt  (radar_start_evt),
      .radar_active     (radar_active),
      .err_step_in_dwell(err_step_in_dwell),
      .busy             (busy),
      .scan_slips       (scan_slips),
      .scan_pairs       (scan_pairs),
      .summary_valid    (summary_valid)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Cumulative count of high cycles on each event output
   int sd_n = 0, stop_n = 0, start_n = 0, sv_n = 0;
   always @(negedge clk) begin
      sd_n    += int'(slip_done);
      stop_n  += int'(radar_stop_evt);
      start_n += int'(radar_start_evt);
      sv_n    += int'(summary_valid);
   end

   // Scan model, one update per transaction
   logic signed [31:0] m_pos;
   logic [31:0] m_sis, m_slip, m_pairs, m_pp, m_scan_slips, m_scan_pairs;
   logic        m_active, m_err, m_busy;
   int          m_sd_n = 0, m_stop_n = 0, m_start_n = 0, m_sv_n = 0;

   function automatic void m_reset();
      m_pos = 0; m_sis = 0; m_slip = 0; m_pairs = 0; m_pp = 0;
      m_scan_slips = 0; m_scan_pairs = 0;
      m_active = 1'b1; m_err = 1'b0; m_busy = 1'b0;
   endfunction

   function automatic void m_step(input logic d);
      m_pos  = d ? m_pos + 1 : m_pos - 1;
      m_busy = 1'b1;
      if (!m_active) m_err = 1'b1;
      if (m_pp != 0) begin
         if (m_sis + 1 >= m_pp) begin
            m_sis = 0; m_slip = m_slip + 1; m_sd_n++;
         end else begin
            m_sis = m_sis + 1;
         end
      end
   endfunction

   function automatic void m_strobe(input int w);
      if (w >= 4) begin
         if (m_active) begin
            m_active = 1'b0; m_stop_n++;
         end else begin
            m_active = 1'b1; m_pairs = m_pairs + 1; m_start_n++;
         end
      end
   endfunction

   function automatic void m_event();
      m_scan_slips = m_slip; m_scan_pairs = m_pairs; m_sv_n++;
      m_slip = 0; m_sis = 0; m_pairs = 0; m_busy = 1'b0; m_active = 1'b1;
   endfunction

   function automatic void m_clear();
      m_pos = 0; m_sis = 0; m_slip = 0; m_pairs = 0; m_err = 1'b0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; h_pwm_pulse = 1'b0; radar_ss = 1'b0; clear_pos = 1'b0;
      event_done = 1'b0; data_update = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      m_reset();
   endtask

   task automatic do_step(input logic d);
      h_pwm_dir = d; tick(1);
      h_pwm_pulse = 1'b1; tick(2);
      h_pwm_pulse = 1'b0; tick(6);
      m_step(d);
   endtask

   task automatic do_strobe(input int w);
      radar_ss = 1'b1; tick(w);
      radar_ss = 1'b0; tick(8);
      m_strobe(w);
   endtask

   task automatic set_pp(input logic [31:0] v);
      pulses_per_slip = v; data_update = 1'b1; tick(1);
      data_update = 1'b0; m_pp = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      total++;
      if ({position, step_in_slip, slip_cnt, scan_slips, scan_pairs} !== 160'd0)
         $display("FAIL reset_counters: got %h want 0",
                  {position, step_in_slip, slip_cnt, scan_slips, scan_pairs});
      else passed++;
      total++;
      if ({slip_done, radar_stop_evt, radar_start_evt, radar_active, err_step_in_dwell,
           busy, summary_valid} !== 7'b0001000)
         $display("FAIL reset_flags: got %b want 0001000",
                  {slip_done, radar_stop_evt, radar_start_evt, radar_active,
                   err_step_in_dwell, busy, summary_valid});
      else passed++;
      do_reset();
   endtask

   task automatic test_slip();
      logic [31:0] p0;
      do_reset();
      set_pp(32'd4);
      p0 = position;
      h_pwm_dir = 1'b1; tick(1);
      h_pwm_pulse = 1'b1; tick(3);
      total++;
      if (position !== p0) $display("FAIL step_lat_early: got %0d want %0d", position, p0);
      else passed++;
      tick(1);
      total++;
      if (position !== p0 + 32'd1)
         $display("FAIL step_lat_n3: got %0d want %0d", position, p0 + 32'd1);
      else passed++;
      h_pwm_pulse = 1'b0; tick(6);
      m_step(1'b1);
      for (int i = 0; i < 9; i++) do_step(1'b1);
      total++;
      if ({position, slip_cnt, step_in_slip} !== {32'd10, 32'd2, 32'd2})
         $display("FAIL slip_ten: got pos %0d slips %0d sis %0d want 10 2 2",
                  position, slip_cnt, step_in_slip);
      else passed++;
      total++;
      if (sd_n !== m_sd_n) $display("FAIL slip_done_cnt: got %0d want %0d", sd_n, m_sd_n);
      else passed++;
      total++;
      if (busy !== 1'b1) $display("FAIL busy_set: got %b want 1", busy);
      else passed++;
      // shrinking ppslip below the current step count wraps on the next step
      set_pp(32'd2);
      do_step(1'b1);
      total++;
      if ({slip_cnt, step_in_slip} !== {32'd3, 32'd0})
         $display("FAIL pp_shrink: got slips %0d sis %0d want 3 0", slip_cnt, step_in_slip);
      else passed++;
   endtask

   task automatic test_dir_clear();
      do_reset();
      for (int i = 0; i < 3; i++) do_step(1'b0);
      total++;
      if (position !== 32'hFFFF_FFFD)
         $display("FAIL dir_neg: got %0d want -3", $signed(position));
      else passed++;
      total++;
      if (step_in_slip !== 32'd0)
         $display("FAIL pp_zero: got %0d want 0", step_in_slip);
      else passed++;
      h_pwm_dir = 1'b0; tick(1);
      h_pwm_pulse = 1'b1; tick(3);
      clear_pos = 1'b1; tick(1);
      clear_pos = 1'b0; h_pwm_pulse = 1'b0; tick(6);
      m_clear();
      total++;
      if (position !== 32'd0) $display("FAIL clear_step: got %0d want 0", $signed(position));
      else passed++;
   endtask

   task automatic test_strobe();
      do_reset();
      do_strobe(2);
      do_strobe(3);
      total++;
      if ({stop_n, start_n, 31'd0, radar_active} !== {m_stop_n, m_start_n, 31'd0, 1'b1})
         $display("FAIL glitch: got stops %0d starts %0d act %b want %0d %0d 1",
                  stop_n, start_n, radar_active, m_stop_n, m_start_n);
      else passed++;
      radar_ss = 1'b1; tick(6);
      radar_ss = 1'b0; tick(4);
      total++;
      if (radar_active !== 1'b1) $display("FAIL ss_lat_early: got %b want 1", radar_active);
      else passed++;
      tick(1);
      total++;
      if ({radar_active, radar_stop_evt} !== 2'b01)
         $display("FAIL ss_lat_f4: got act %b stop %b want 0 1", radar_active, radar_stop_evt);
      else passed++;
      tick(6);
      m_strobe(6);
      do_strobe(4);
      total++;
      if ({radar_active, stop_n, start_n} !== {1'b1, m_stop_n, m_start_n})
         $display("FAIL start_min: got act %b stops %0d starts %0d want 1 %0d %0d",
                  radar_active, stop_n, start_n, m_stop_n, m_start_n);
      else passed++;
   endtask

   task automatic test_dwell();
      do_reset();
      do_strobe(6);
      do_step(1'b1);
      total++;
      if (err_step_in_dwell !== 1'b1) $display("FAIL dwell_set: got %b want 1", err_step_in_dwell);
      else passed++;
      do_strobe(6);
      event_done = 1'b1; tick(1); event_done = 1'b0; tick(2);
      m_event();
      total++;
      if (err_step_in_dwell !== 1'b1)
         $display("FAIL dwell_sticky: got %b want 1", err_step_in_dwell);
      else passed++;
      clear_pos = 1'b1; tick(1); clear_pos = 1'b0; tick(1);
      m_clear();
      total++;
      if (err_step_in_dwell !== 1'b0)
         $display("FAIL dwell_clear: got %b want 0", err_step_in_dwell);
      else passed++;
   endtask

   task automatic test_summary();
      do_reset();
      set_pp(32'd4);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) do_step(1'b1);
         do_strobe(6);
         do_strobe(6);
      end
      event_done = 1'b1; tick(1); event_done = 1'b0;
      m_event();
      total++;
      if ({summary_valid, scan_slips, scan_pairs} !== {1'b1, 32'd3, 32'd3})
         $display("FAIL summary: got v %b slips %0d pairs %0d want 1 3 3",
                  summary_valid, scan_slips, scan_pairs);
      else passed++;
      tick(1);
      total++;
      if ({summary_valid, slip_cnt, step_in_slip, position, busy} !==
          {1'b0, 32'd0, 32'd0, 32'd12, 1'b0})
         $display("FAIL post_summary: got v %b slips %0d sis %0d pos %0d busy %b want 0 0 0 12 0",
                  summary_valid, slip_cnt, step_in_slip, position, busy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_pp(32'd4);
      do_step(1'b1);
      do_step(1'b1);
      do_strobe(6);
      do_step(1'b1);
      radar_ss = 1'b1; tick(3);
      rst = 1'b1; #1;
      total++;
      if ({position, step_in_slip, radar_active, err_step_in_dwell, busy} !==
          {32'd0, 32'd0, 1'b1, 1'b0, 1'b0})
         $display("FAIL reset_mid: got pos %0d sis %0d act %b err %b busy %b want 0 0 1 0 0",
                  position, step_in_slip, radar_active, err_step_in_dwell, busy);
      else passed++;
      radar_ss = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      m_reset();
      do_strobe(6);
      do_step(1'b1);
      total++;
      if ({radar_active, stop_n, step_in_slip, err_step_in_dwell} !==
          {1'b0, m_stop_n, 32'd0, 1'b1})
         $display("FAIL after_reset: got act %b stops %0d sis %0d err %b want 0 %0d 0 1",
                  radar_active, stop_n, step_in_slip, err_step_in_dwell, m_stop_n);
      else passed++;
   endtask

   task automatic test_random();
      int op;
      logic d;
      int w;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         set_pp($urandom_range(0, 5));
         for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            if (op < 6) begin
               d = 1'($urandom_range(0, 1));
               do_step(d);
            end else if (op < 9) begin
               w = $urandom_range(1, 8);
               do_strobe(w);
            end else begin
               set_pp($urandom_range(0, 5));
            end
            total++;
            if ({position, step_in_slip, slip_cnt, radar_active, err_step_in_dwell, busy} !==
                {m_pos, m_sis, m_slip, m_active, m_err, m_busy})
               $display("FAIL rand_state r%0d i%0d: got %0d %0d %0d %b%b%b want %0d %0d %0d %b%b%b",
                        r, i, $signed(position), step_in_slip, slip_cnt, radar_active,
                        err_step_in_dwell, busy, m_pos, m_sis, m_slip, m_active, m_err, m_busy);
            else passed++;
         end
         event_done = 1'b1; tick(1); event_done = 1'b0;
         m_event();
         total++;
         if ({summary_valid, scan_slips, scan_pairs} !== {1'b1, m_scan_slips, m_scan_pairs})
            $display("FAIL rand_summary r%0d: got v %b %0d %0d want 1 %0d %0d", r,
                     summary_valid, scan_slips, scan_pairs, m_scan_slips, m_scan_pairs);
         else passed++;
         tick(2);
         total++;
         if ({sd_n, stop_n, start_n, sv_n} !== {m_sd_n, m_stop_n, m_start_n, m_sv_n})
            $display("FAIL rand_pulses r%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", r,
                     sd_n, stop_n, start_n, sv_n, m_sd_n, m_stop_n, m_start_n, m_sv_n);
         else passed++;
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_slip();
      test_dir_clear();
      test_strobe();
      test_dwell();
      test_summary();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
